// File: rtl/serial_time_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_time_adder_pkg
//
// Purpose : Shared definitions for the bit-serial time adder. Holds the
//           2-bit FSM state encoding and the helper that sizes the bit
//           counter so that it can hold the value WIDTH without wrapping.
//
// Contents:
//   state_t        2-bit state type
//   ST_IDLE  = 0   waiting for start
//   ST_SHIFT = 1   one result bit produced per clock
//   ST_DONE  = 2   one-cycle completion state (done pulse)
//   cnt_width(w)   ceil(log2(w+1)), the number of bits needed to count 0..w
// ---------------------------------------------------------------------------
package serial_time_adder_pkg;

  typedef logic [1:0] state_t;

  // State encodings stay plain constants so older modules comparing raw
  // 2-bit values keep working.
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Smallest n with 2**n >= w+1, so a counter of this width can reach w
  // itself. The loop bound covers every legal WIDTH (2..32) with margin.
  function automatic int cnt_width(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << n) < (w + 1)) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/serial_time_adder_full_adder.sv
// ---------------------------------------------------------------------------
// fullAdder
//
// Purpose : One-bit full adder, the single arithmetic stage reused by the
//           bit-serial adder. Purely combinational.
//
// Ports:
//   a, b  input   operand bits
//   cin   input   carry into this bit
//   s     output  sum bit  (a ^ b ^ cin)
//   cout  output  carry out of this bit
// ---------------------------------------------------------------------------
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Carry is generated when both operands are set, or propagated when
  // exactly one is set and a carry arrives.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_time_adder.sv
// ---------------------------------------------------------------------------
// serial_time_adder
//
// Purpose : Adds two WIDTH-bit time values plus a carry-in, LSB first, one
//           bit per clock through a single full-adder stage with a
//           registered carry. Result and carry-out are published together
//           on completion and held until the next completion.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports:
//   clk    input          system clock, rising-edge active
//   rst    input          synchronous active-high reset
//   start  input          request to begin an addition (IDLE or DONE only)
//   op_a   input  [W-1:0] first operand, captured on an accepted start
//   op_b   input  [W-1:0] second operand, captured on an accepted start
//   cin    input          carry-in, captured on an accepted start
//   busy   output         high while bits are being processed (SHIFT)
//   done   output         one-cycle pulse: sum/cout just became valid
//   sum    output [W-1:0] (op_a + op_b + cin) mod 2**WIDTH
//   cout   output         carry out of bit WIDTH-1
//
// Timing: start accepted at edge k -> busy for WIDTH cycles -> done high in
// the cycle after edge k+WIDTH. A start during that done cycle chains
// straight into the next addition with no idle gap.
// ---------------------------------------------------------------------------
module serial_time_adder
  import serial_time_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  // Counter value seen on the edge that produces the final (MSB) bit.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic [CW-1:0]    bit_cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] result_shifted;

  // The only arithmetic in the block: current LSBs plus the carry kept
  // from the previous bit.
  fullAdder u_full_adder (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .s    (fa_sum),
    .cout (fa_carry)
  );

  // A new request is taken only when no addition is in flight; a start
  // seen in SHIFT simply falls through and changes nothing.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);

  // Sum bits enter from the MSB end, so after WIDTH shifts the first
  // (LSB) bit has walked all the way down to bit 0.
  assign result_shifted = {fa_sum, result_reg[WIDTH-1:1]};

  // Next-state logic. DONE lasts exactly one cycle and either chains into
  // a new SHIFT (start present) or returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: operand shift registers, carry flop, bit counter and the
  // partial result. On an accepted start everything is reloaded; in SHIFT
  // one bit is consumed per edge. Reset wipes all of it so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      bit_cnt    <= '0;
    end else if (accept) begin
      a_reg      <= op_a;
      b_reg      <= op_b;
      result_reg <= '0;
      carry_reg  <= cin;
      bit_cnt    <= '0;
    end else if (state == ST_SHIFT) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      result_reg <= result_shifted;
      carry_reg  <= fa_carry;
      bit_cnt    <= bit_cnt + CW'(1);
    end
  end

  // Published result. Updated only on the edge that produces the last bit,
  // so the outputs never show a partially built sum and hold their value
  // across IDLE and any following addition until it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= result_shifted;
      cout <= fa_carry;
    end
  end

  // Status outputs are pure state decodes, so busy and done are mutually
  // exclusive by construction.
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: doc/serial_time_adder.md
SERIAL_TIME_ADDER -- requirements
Module: serial_time_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal range 2..32.
REQ-002 Clocking: one clock domain; reset is synchronous, active-high, sampled only on the rising edge of clk.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin an addition; sampled each rising edge.
REQ-006 op_a  input  WIDTH  first time operand; captured only on an accepted start.
REQ-007 op_b  input  WIDTH  second time operand; captured only on an accepted start.
REQ-008 cin  input  1  carry-in; captured only on an accepted start.
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-011 sum  output  WIDTH  result of op_a + op_b + cin, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL add LSB-first, one bit per clock, through a single one-bit full-adder stage with a registered carry.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 Start SHALL be accepted only in IDLE or DONE.
- On acceptance: load op_a, op_b into shift registers; carry register <= cin; bit counter <= 0; next state SHIFT.
REQ-016 In SHIFT, each edge SHALL:
- form a[0]+b[0]+carry;
- shift the sum bit into the result register from the MSB end;
- update carry;
- shift both operand registers right by one;
- increment the counter.
REQ-017 After the WIDTH-th SHIFT edge, the FSM SHALL enter DONE; on that same edge sum <= result and cout <= final carry.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH, then DONE exits to IDLE unless start is high.
REQ-019 busy SHALL be high exactly while in SHIFT, for WIDTH cycles.
- busy and done SHALL never be high together.
REQ-020 start while in SHIFT SHALL be ignored, with no effect on operands, counter or result.
REQ-021 start high during the DONE cycle SHALL be accepted: the next cycle is SHIFT with new operands and no IDLE gap.
REQ-022 sum and cout SHALL hold their last values from the end of DONE until the next completion edge.
- sum and cout SHALL NOT show partial results while busy.
REQ-023 Overflow beyond WIDTH bits SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within one operation.

Reset
REQ-025 On rst=1 at a rising edge, state SHALL go to IDLE.
- busy=0, done=0, sum=0, cout=0.
- Carry, counter and shift registers SHALL all be cleared.
REQ-026 rst SHALL take priority over start, including a start on the same edge.
REQ-027 rst during SHIFT SHALL abort the operation; no done pulse follows.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, SHIFT=1, DONE=2) and the counter-width function.
REQ-029 The one-bit addition SHALL be a single instance of the team's existing fullAdder sub-module.
- The carry flop, shift registers and FSM SHALL live in serial_time_adder.

Verification (WIDTH=8)
REQ-030 op_a=0x3C, op_b=0x15, cin=0, start at edge k -> busy high for 8 cycles; done pulse after edge k+8; sum=0x51, cout=0.
REQ-031 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1.
- Then op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Start with 0x10+0x20, then start pulsed with 0xAA+0x55 at SHIFT cycle 3 -> second request ignored; sum=0x30, cout=0.
REQ-033 rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, sum=0x00; no done pulse for 10 cycles.
REQ-034 start held high through DONE with new operands 0x01+0x01 -> SHIFT resumes the next cycle; second done exactly 9 cycles after the first with sum=0x02.
